// File: rtl/lsu_arbiter_if.sv
// lsu_arbiter_if: requester and LSU side signals of the load/store arbiter.
//   slave  modport : arbiter view (requests and LSU read data in; acks, strobes out)
//   master modport : environment view (requesters plus LSU)
// Signals:
//   f_req/f_addr/f_ack/f_data             fetch requester handshake
//   d_req/d_op/d_addr/d_wdata/d_ack/d_rdata data requester handshake
//   lsu_a/lsu_d/lsu_re/lsu_we             LSU address, write byte, strobes
//   lsu_sp_en/lsu_sp_we/lsu_sp_d          stack-pointer select, update, direction
//   lsu_q/lsu_q1/lsu_q2                   LSU read bytes at a, a+1, a+2
//   busy                                  arbiter not idle
interface lsu_arbiter_if;
   localparam int unsigned AW = 16;
   localparam int unsigned BW = 8;
   localparam int unsigned FW = 24;

   logic          f_req;
   logic [AW-1:0] f_addr;
   logic          f_ack;
   logic [FW-1:0] f_data;

   logic          d_req;
   logic [1:0]    d_op;
   logic [AW-1:0] d_addr;
   logic [BW-1:0] d_wdata;
   logic          d_ack;
   logic [BW-1:0] d_rdata;

   logic [AW-1:0] lsu_a;
   logic [BW-1:0] lsu_d;
   logic          lsu_re;
   logic          lsu_we;
   logic          lsu_sp_en;
   logic          lsu_sp_we;
   logic          lsu_sp_d;
   logic [BW-1:0] lsu_q;
   logic [BW-1:0] lsu_q1;
   logic [BW-1:0] lsu_q2;

   logic          busy;

   modport slave (
      input  f_req, f_addr, d_req, d_op, d_addr, d_wdata,
      input  lsu_q, lsu_q1, lsu_q2,
      output f_ack, f_data, d_ack, d_rdata,
      output lsu_a, lsu_d, lsu_re, lsu_we, lsu_sp_en, lsu_sp_we, lsu_sp_d,
      output busy
   );

   modport master (
      output f_req, f_addr, d_req, d_op, d_addr, d_wdata,
      output lsu_q, lsu_q1, lsu_q2,
      input  f_ack, f_data, d_ack, d_rdata,
      input  lsu_a, lsu_d, lsu_re, lsu_we, lsu_sp_en, lsu_sp_we, lsu_sp_d,
      input  busy
   );
endinterface

// File: rtl/lsu_arbiter.sv
// lsu_arbiter: arbitrates a fetch port and a data port (load/store/push/pop)
// onto a single LSU. Fixed priority, data over fetch.
// Optional feature macro STARVE_GUARD_EN: after STARVE_LIMIT consecutive data
// grants made while fetch was waiting, fetch wins the next arbitration.
// Ports:
//   clk            rising-edge clock
//   rst            synchronous active-high reset; also blocks LSU writes at once
//   bus (slave)    requester handshakes, LSU strobes/data, busy
// Parameters:
//   STARVE_LIMIT   data grants tolerated before a pending fetch is forced
module lsu_arbiter #(
   parameter int unsigned STARVE_LIMIT = 4
) (
   input  logic         clk,
   input  logic         rst,
   lsu_arbiter_if.slave bus
);

   localparam int unsigned AW = 16;
   localparam int unsigned BW = 8;
   localparam int unsigned FW = 24;

   localparam logic [1:0] OP_LOAD  = 2'b00;
   localparam logic [1:0] OP_STORE = 2'b01;
   localparam logic [1:0] OP_PUSH  = 2'b10;
   localparam logic [1:0] OP_POP   = 2'b11;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_DEC   = 2'd1,
      S_ISSUE = 2'd2,
      S_RESP  = 2'd3
   } state_t;

   // Captured operation kind; K_NONE is the reset value.
   typedef enum logic [2:0] {
      K_NONE  = 3'd0,
      K_FETCH = 3'd1,
      K_LOAD  = 3'd2,
      K_STORE = 3'd3,
      K_PUSH  = 3'd4,
      K_POP   = 3'd5
   } kind_t;

   // A limit of zero would force every fetch and starve data instead.
   if (STARVE_LIMIT == 0) begin : g_bad_limit
      $error("lsu_arbiter: STARVE_LIMIT must be at least 1");
   end

   state_t        state;
   state_t        state_nx;
   kind_t         cap_kind;
   logic [AW-1:0] cap_addr;
   logic [BW-1:0] cap_wdata;

   logic          grant_d_c;
   logic          grant_f_c;

   logic          f_ack_q;
   logic [FW-1:0] f_data_q;
   logic          d_ack_q;
   logic [BW-1:0] d_rdata_q;

   logic [AW-1:0] lsu_a_c;
   logic [BW-1:0] lsu_d_c;
   logic          lsu_re_c;
   logic          lsu_we_c;
   logic          lsu_sp_en_c;
   logic          lsu_sp_we_c;
   logic          lsu_sp_d_c;
   logic          busy_c;

   // Arbitration, only meaningful in IDLE.
`ifdef STARVE_GUARD_EN
   localparam int unsigned CNT_W = $clog2(STARVE_LIMIT + 1);

   logic [CNT_W-1:0] starve_cnt;
   logic             starve_hit_c;

   assign starve_hit_c = (starve_cnt == CNT_W'(STARVE_LIMIT));
   assign grant_d_c    = bus.d_req && !(starve_hit_c && bus.f_req);

   // Counts data grants that overtook a waiting fetch; any fetch grant resets it.
   always_ff @(posedge clk) begin
      if (rst) begin
         starve_cnt <= '0;
      end else if (state == S_IDLE) begin
         if (grant_f_c) begin
            starve_cnt <= '0;
         end else if (grant_d_c && bus.f_req) begin
            starve_cnt <= starve_cnt + CNT_W'(1);
         end
      end
   end
`else
   assign grant_d_c = bus.d_req;
`endif

   assign grant_f_c = bus.f_req && !grant_d_c;

   // State register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= S_IDLE;
      end else begin
         state <= state_nx;
      end
   end

   // Next-state logic; pop takes an extra cycle to pre-decrement sp.
   always_comb begin
      state_nx = state;
      case (state)
         S_IDLE: begin
            if (grant_d_c) begin
               state_nx = (bus.d_op == OP_POP) ? S_DEC : S_ISSUE;
            end else if (grant_f_c) begin
               state_nx = S_ISSUE;
            end
         end
         S_DEC:   state_nx = S_ISSUE;
         S_ISSUE: state_nx = S_RESP;
         S_RESP:  state_nx = S_IDLE;
         default: state_nx = S_IDLE;
      endcase
   end

   // Capture the granted request so later input changes cannot disturb it.
   always_ff @(posedge clk) begin
      if (rst) begin
         cap_kind  <= K_NONE;
         cap_addr  <= '0;
         cap_wdata <= '0;
      end else if (state == S_IDLE) begin
         if (grant_d_c) begin
            case (bus.d_op)
               OP_LOAD:  cap_kind <= K_LOAD;
               OP_STORE: cap_kind <= K_STORE;
               OP_PUSH:  cap_kind <= K_PUSH;
               default:  cap_kind <= K_POP;
            endcase
            cap_addr  <= bus.d_addr;
            cap_wdata <= bus.d_wdata;
         end else if (grant_f_c) begin
            cap_kind  <= K_FETCH;
            cap_addr  <= bus.f_addr;
            cap_wdata <= '0;
         end
      end
   end

   // LSU strobes from state and captured registers only.
   always_comb begin
      lsu_a_c     = '0;
      lsu_d_c     = '0;
      lsu_re_c    = 1'b0;
      lsu_we_c    = 1'b0;
      lsu_sp_en_c = 1'b0;
      lsu_sp_we_c = 1'b0;
      lsu_sp_d_c  = 1'b0;
      busy_c      = (state != S_IDLE);
      case (state)
         S_DEC: begin
            lsu_sp_en_c = 1'b1;
            lsu_sp_we_c = 1'b1;
            lsu_sp_d_c  = 1'b0;
         end
         S_ISSUE: begin
            case (cap_kind)
               K_FETCH, K_LOAD: begin
                  lsu_re_c = 1'b1;
                  lsu_a_c  = cap_addr;
               end
               K_STORE: begin
                  lsu_we_c = 1'b1;
                  lsu_a_c  = cap_addr;
                  lsu_d_c  = cap_wdata;
               end
               K_PUSH: begin
                  // Write at sp, then post-increment.
                  lsu_sp_en_c = 1'b1;
                  lsu_we_c    = 1'b1;
                  lsu_sp_we_c = 1'b1;
                  lsu_sp_d_c  = 1'b1;
                  lsu_d_c     = cap_wdata;
               end
               K_POP: begin
                  lsu_sp_en_c = 1'b1;
                  lsu_re_c    = 1'b1;
               end
               default: ;
            endcase
         end
         default: ;
      endcase
      // Writes are blocked the moment reset is seen, even mid-operation.
      if (rst) begin
         lsu_we_c    = 1'b0;
         lsu_sp_we_c = 1'b0;
      end
   end

   // Response capture and single-cycle ack pulses; data holds between acks.
   always_ff @(posedge clk) begin
      if (rst) begin
         f_ack_q   <= 1'b0;
         d_ack_q   <= 1'b0;
         f_data_q  <= '0;
         d_rdata_q <= '0;
      end else begin
         f_ack_q <= 1'b0;
         d_ack_q <= 1'b0;
         if (state == S_RESP) begin
            if (cap_kind == K_FETCH) begin
               f_data_q <= {bus.lsu_q2, bus.lsu_q1, bus.lsu_q};
               f_ack_q  <= 1'b1;
            end else begin
               d_ack_q <= 1'b1;
               if ((cap_kind == K_LOAD) || (cap_kind == K_POP)) begin
                  d_rdata_q <= bus.lsu_q;
               end
            end
         end
      end
   end

   assign bus.f_ack     = f_ack_q;
   assign bus.f_data    = f_data_q;
   assign bus.d_ack     = d_ack_q;
   assign bus.d_rdata   = d_rdata_q;
   assign bus.lsu_a     = lsu_a_c;
   assign bus.lsu_d     = lsu_d_c;
   assign bus.lsu_re    = lsu_re_c;
   assign bus.lsu_we    = lsu_we_c;
   assign bus.lsu_sp_en = lsu_sp_en_c;
   assign bus.lsu_sp_we = lsu_sp_we_c;
   assign bus.lsu_sp_d  = lsu_sp_d_c;
   assign bus.busy      = busy_c;

endmodule
